// File: rtl/point_frame_rx_if.sv
// rtl/point_frame_rx_if.sv - link byte/ack and payload output stream bundle for point_frame_rx
interface point_frame_rx_if;
    logic [7:0] link_data;
    logic       link_resp;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    // Far end / consumer side
    modport master (output link_data, output out_ready,
                    input  link_resp, input  out_data, input out_valid);
    // Receiver side
    modport slave  (input  link_data, input  out_ready,
                    output link_resp, output out_data, output out_valid);
endinterface

// File: rtl/point_frame_rx.sv
// rtl/point_frame_rx.sv - framed byte receiver with commit/rollback payload FIFO (option macro: P2P_RX_CSUM_EN)
module point_frame_rx #(
    parameter int         DEPTH = 16,
    parameter logic [7:0] SOF   = 8'h7E,
    parameter int         CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    point_frame_rx_if.slave  link,
    output logic             frame_err,
    output logic [CNT_W-1:0] ok_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int AW = $clog2(DEPTH);

`ifdef P2P_RX_CSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD} state_t;
`endif

    state_t           state_q;
    logic [7:0]       rem_q;
    logic             ovf_q;
`ifdef P2P_RX_CSUM_EN
    logic [7:0]       sum_q;
`endif
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]      rd_q, wc_q, ws_q;
    logic [AW:0]      rd_d, wc_d, ws_d, ws_inc;
    logic [7:0]       mem [DEPTH];
    logic [7:0]       out_data_q, head_d;
    logic             out_valid_q, resp_q, ferr_q;
    logic [CNT_W-1:0] ok_q, errc_q;
    logic             full, pop, we, commit, reject;

    // Per-byte decode: write enable, commit/reject decision and next pointers
    always_comb begin
        full   = ((ws_q - rd_q) == (AW+1)'(DEPTH));
        pop    = out_valid_q && link.out_ready;
        we     = 1'b0;
        commit = 1'b0;
        reject = 1'b0;
        case (state_q)
`ifndef P2P_RX_CSUM_EN
            S_LEN: begin
                if (link.link_data == 8'd0) commit = 1'b1;
            end
`endif
            S_PAYLOAD: begin
                we = !full;
`ifndef P2P_RX_CSUM_EN
                if (rem_q == 8'd1) begin
                    if (ovf_q || full) reject = 1'b1;
                    else               commit = 1'b1;
                end
`endif
            end
`ifdef P2P_RX_CSUM_EN
            S_CSUM: begin
                if (ovf_q || (8'(sum_q + link.link_data) != 8'd0)) reject = 1'b1;
                else                                               commit = 1'b1;
            end
`endif
            default: ;
        endcase
        ws_inc = ws_q + (AW+1)'(we);
        ws_d   = reject ? wc_q : ws_inc;
        wc_d   = commit ? ws_inc : wc_q;
        rd_d   = rd_q + (AW+1)'(pop);
        // A byte written this edge may become the new head (last-byte commit)
        if (we && (ws_q[AW-1:0] == rd_d[AW-1:0])) head_d = link.link_data;
        else                                      head_d = mem[rd_d[AW-1:0]];
    end

    // Payload storage; never reset, contents are only reachable via the pointers
    always_ff @(posedge clock) begin
        if (we) mem[ws_q[AW-1:0]] <= link.link_data;
    end

    // Frame parser FSM, pointers and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rem_q       <= 8'd0;
            ovf_q       <= 1'b0;
`ifdef P2P_RX_CSUM_EN
            sum_q       <= 8'd0;
`endif
            rd_q        <= '0;
            wc_q        <= '0;
            ws_q        <= '0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            resp_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ok_q        <= '0;
            errc_q      <= '0;
        end else begin
            rd_q        <= rd_d;
            wc_q        <= wc_d;
            ws_q        <= ws_d;
            out_valid_q <= (wc_d != rd_d);
            out_data_q  <= head_d;
            resp_q      <= commit;
            ferr_q      <= reject;
            if (commit) ok_q   <= ok_q + CNT_W'(1);
            if (reject) errc_q <= errc_q + CNT_W'(1);
            case (state_q)
                S_IDLE: begin
                    if (link.link_data == SOF) state_q <= S_LEN;
                end
                S_LEN: begin
                    rem_q <= link.link_data;
                    ovf_q <= 1'b0;
`ifdef P2P_RX_CSUM_EN
                    sum_q <= link.link_data;
                    state_q <= (link.link_data == 8'd0) ? S_CSUM : S_PAYLOAD;
`else
                    state_q <= (link.link_data == 8'd0) ? S_IDLE : S_PAYLOAD;
`endif
                end
                S_PAYLOAD: begin
                    rem_q <= rem_q - 8'd1;
                    if (full) ovf_q <= 1'b1;
`ifdef P2P_RX_CSUM_EN
                    sum_q <= sum_q + link.link_data;
                    if (rem_q == 8'd1) state_q <= S_CSUM;
`else
                    if (rem_q == 8'd1) state_q <= S_IDLE;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign link.link_resp = resp_q;
    assign link.out_data  = out_data_q;
    assign link.out_valid = out_valid_q;
    assign frame_err      = ferr_q;
    assign ok_count       = ok_q;
    assign err_count      = errc_q;
endmodule

// File: tb/tb_point_frame_rx.sv
// tb/tb_point_frame_rx.sv - randomized frame stimulus against a frame-level reference model
module tb_point_frame_rx;
    localparam int DEPTH = 16;
    localparam int CNT_W = 8;
`ifdef P2P_RX_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             frame_err;
    logic [CNT_W-1:0] ok_count, err_count;

    point_frame_rx_if bus();

    point_frame_rx #(.DEPTH(DEPTH), .SOF(8'h7E), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .link      (bus),
        .frame_err (frame_err),
        .ok_count  (ok_count),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;           // 0 hold low, 1 hold high, 2 random
    byte unsigned exp_q[$];       // committed payload the consumer should see, in order
    byte unsigned got_q[$];       // payload actually popped
    int m_ok = 0;
    int m_err = 0;

    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clock) begin
        if (reset_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            got_q.push_back(bus.out_data);
    end

    task automatic send_byte(input byte unsigned b);
        bus.link_data = b;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (bus.out_valid === 1'b1 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic compare_stream(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d bytes required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_data[%0d]: got %02h required %02h", name, i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Send one frame; the model decides acceptance from occupancy and checksum rules
    task automatic send_frame(input byte unsigned pl[$], input bit corrupt, input bit gap);
        int           len = pl.size();
        byte unsigned s;
        bit           good;
        good = !(corrupt && CSUM_EN) && ((exp_q.size() - got_q.size()) + len <= DEPTH);
        send_byte(8'h7E);
        send_byte(8'(len));
        s = 8'(len);
        foreach (pl[i]) begin
            send_byte(pl[i]);
            s = s + pl[i];
        end
        if (CSUM_EN) send_byte(corrupt ? 8'(8'd1 - s) : 8'(8'd0 - s));
        bus.link_data = 8'h00;
        if (good) begin
            foreach (pl[i]) exp_q.push_back(pl[i]);
            m_ok++;
        end else begin
            m_err++;
        end
        checks++;
        if (bus.link_resp !== good) begin
            errors++;
            $display("FAIL ack: link_resp=%b required %b (len %0d)", bus.link_resp, good, len);
        end
        checks++;
        if (frame_err !== !good) begin
            errors++;
            $display("FAIL frame_err: got %b required %b (len %0d)", frame_err, !good, len);
        end
        checks++;
        if (ok_count !== CNT_W'(m_ok) || err_count !== CNT_W'(m_err)) begin
            errors++;
            $display("FAIL counters: ok=%0d err=%0d required ok=%0d err=%0d",
                     ok_count, err_count, CNT_W'(m_ok), CNT_W'(m_err));
        end
        if (gap) begin
            send_byte(8'h00);
            checks++;
            if (bus.link_resp !== 1'b0 || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL pulse_width: link_resp=%b frame_err=%b required 0 0", bus.link_resp, frame_err);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.link_data = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: valid=%b data=%02h required 0 00", bus.out_valid, bus.out_data);
        end
        checks++;
        if (bus.link_resp !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: resp=%b ferr=%b required 0 0", bus.link_resp, frame_err);
        end
        checks++;
        if (ok_count !== '0 || err_count !== '0) begin
            errors++;
            $display("FAIL reset_counters: ok=%0d err=%0d required 0 0", ok_count, err_count);
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        byte unsigned pl[$];
        ready_mode = 1;
        @(posedge clock); #1;
        pl = {8'h11, 8'h22, 8'h33};
        send_frame(pl, 1'b0, 1'b1);
        wait_drain(50);
        compare_stream("basic");
    endtask

    task automatic test_bad_csum();
        byte unsigned pl[$];
        pl = {8'hAA, 8'hBB};
        send_frame(pl, 1'b1, 1'b1);
        wait_drain(50);
        compare_stream("bad_csum");
    endtask

    task automatic test_overflow();
        byte unsigned pl[$];
        ready_mode = 0;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
        send_frame(pl, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_valid: out_valid=%b required 0", bus.out_valid);
        end
        pl.delete();
        for (int i = 0; i < DEPTH; i++) pl.push_back(8'($urandom));
        send_frame(pl, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_valid: out_valid=%b required 1", bus.out_valid);
        end
        ready_mode = 1;
        wait_drain(100);
        compare_stream("full");
    endtask

    task automatic test_junk_zero();
        byte unsigned pl[$];
        send_byte(8'h00);
        send_byte(8'h55);
        send_frame(pl, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_valid: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        byte unsigned pl[$];
        ready_mode = 0;
        send_byte(8'h7E);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h02);
        reset_n = 1'b0;
        bus.link_data = 8'h00;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || ok_count !== '0 || err_count !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%b ok=%0d err=%0d required 0 0 0", bus.out_valid, ok_count, err_count);
        end
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        m_ok = 0;
        m_err = 0;
        ready_mode = 1;
        @(posedge clock); #1;
        pl = {8'h5A};
        send_frame(pl, 1'b0, 1'b1);
        wait_drain(50);
        compare_stream("after_reset");
    endtask

    task automatic test_random();
        byte unsigned pl[$];
        for (int f = 0; f < 25; f++) begin
            ready_mode = 2;
            wait_drain(400);
            pl.delete();
            for (int i = 0; i < $urandom_range(0, DEPTH); i++) pl.push_back(8'($urandom));
            send_frame(pl, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        ready_mode = 1;
        @(posedge clock); #1;
        wait_drain(200);
        compare_stream("random");
    endtask

    task automatic test_back_to_back();
        byte unsigned pl[$];
        ready_mode = 1;
        for (int f = 0; f < 4; f++) begin
            pl.delete();
            for (int i = 0; i < $urandom_range(1, 4); i++) pl.push_back(8'($urandom));
            send_frame(pl, 1'b0, 1'b0);
        end
        wait_drain(100);
        compare_stream("back_to_back");
    endtask

    initial begin
        bus.link_data = 8'h00;
        test_reset();
        test_basic();
        test_bad_csum();
        test_overflow();
        test_junk_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
